// File: rtl/vram_access_arbiter_if.sv
// Signal bundle between the VRAM arbiter, its two requesters (video fetch, CPU) and the SRAM.
// The master modport is the arbiter's view; the slave modport is the requesters' and SRAM's view.
interface vram_access_arbiter_if #(
    parameter int AddrWidth = 16
);
    // video fetch port (read-only)
    logic                 i_vid_req;
    logic [AddrWidth-1:0] i_vid_addr;
    logic                 o_vid_ack;
    logic                 o_vid_rvalid;
    logic [7:0]           o_vid_rdata;

    // CPU port
    logic                 i_cpu_req;
    logic                 i_cpu_we;
    logic [AddrWidth-1:0] i_cpu_addr;
    logic [7:0]           i_cpu_wdata;
    logic                 o_cpu_ack;
    logic                 o_cpu_rvalid;
    logic [7:0]           o_cpu_rdata;

    // SRAM pins and external data bus driver
    logic                 o_ram_ce_b;
    logic                 o_ram_re_b;
    logic                 o_ram_we_b;
    logic [AddrWidth-1:0] o_ram_addr;
    logic [7:0]           o_ram_wdata;
    logic                 o_ram_data_oe_b;
    logic [7:0]           i_ram_rdata;

    logic                 o_busy;

    modport master (
        input  i_vid_req, i_vid_addr,
        output o_vid_ack, o_vid_rvalid, o_vid_rdata,
        input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        output o_cpu_ack, o_cpu_rvalid, o_cpu_rdata,
        output o_ram_ce_b, o_ram_re_b, o_ram_we_b, o_ram_addr, o_ram_wdata, o_ram_data_oe_b,
        input  i_ram_rdata,
        output o_busy
    );

    modport slave (
        output i_vid_req, i_vid_addr,
        input  o_vid_ack, o_vid_rvalid, o_vid_rdata,
        output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        input  o_cpu_ack, o_cpu_rvalid, o_cpu_rdata,
        input  o_ram_ce_b, o_ram_re_b, o_ram_we_b, o_ram_addr, o_ram_wdata, o_ram_data_oe_b,
        output i_ram_rdata,
        input  o_busy
    );
endinterface

// File: rtl/vram_access_arbiter.sv
// Shares one async 8-bit SRAM between the video fetcher and the CPU, sequencing every
// access as ADDR -> STROBE x StrobeCycles -> RECOVER with registered, glitch-free strobes.
module vram_access_arbiter #(
    parameter int AddrWidth    = 16,
    parameter int StrobeCycles = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_b,
    vram_access_arbiter_if.master bus
);
    localparam int CntW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(StrobeCycles - 1);

    typedef enum logic [1:0] {IDLE, ADDR, STROBE, RECOVER} state_e;
    typedef enum logic {PORT_VID, PORT_CPU} port_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    port_e                port_q, last_grant_q;
    logic                 we_q, we_d;
    logic                 vid_wins, cpu_wins, grant_vid, grant_cpu, read_done;

    logic                 ce_b_q, re_b_q, we_b_q, oe_b_q;
    logic [AddrWidth-1:0] addr_q;
    logic [7:0]           wdata_q, vid_rdata_q, cpu_rdata_q;
    logic                 vid_ack_q, cpu_ack_q, vid_rvalid_q, cpu_rvalid_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every variable gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        // on a tie the port that did not win last time takes the slot
        vid_wins  = bus.i_vid_req && (!bus.i_cpu_req || last_grant_q == PORT_CPU);
        cpu_wins  = bus.i_cpu_req && !vid_wins;
        unique case (state_q)
            IDLE, RECOVER: begin
                if (vid_wins || cpu_wins) begin
                    state_d   = ADDR;
                    grant_vid = vid_wins;
                    grant_cpu = cpu_wins;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                state_d = STROBE;
                cnt_d   = '0;
            end
            STROBE: begin
                if (cnt_q == CntLast) state_d = RECOVER;
                else                  cnt_d   = cnt_q + CntW'(1);
            end
            default: state_d = IDLE;
        endcase
        we_d      = grant_cpu ? bus.i_cpu_we : (grant_vid ? 1'b0 : we_q);
        read_done = (state_q == STROBE) && (state_d == RECOVER) && !we_q;
    end

    // Strobes are decoded from the next state and registered, so the SRAM sees clean edges.
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            cnt_q        <= '0;
            port_q       <= PORT_CPU;
            last_grant_q <= PORT_CPU;
            we_q         <= 1'b0;
            ce_b_q       <= 1'b1;
            re_b_q       <= 1'b1;
            we_b_q       <= 1'b1;
            oe_b_q       <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            vid_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
            vid_ack_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            vid_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            we_q  <= we_d;
            if (grant_vid || grant_cpu) begin
                port_q       <= grant_cpu ? PORT_CPU : PORT_VID;
                last_grant_q <= grant_cpu ? PORT_CPU : PORT_VID;
                addr_q       <= grant_cpu ? bus.i_cpu_addr : bus.i_vid_addr;
            end
            if (grant_cpu && bus.i_cpu_we) wdata_q <= bus.i_cpu_wdata;

            ce_b_q <= (state_d == IDLE);
            re_b_q <= !((state_d == STROBE) && !we_d);
            we_b_q <= !((state_d == STROBE) && we_d);
            // driver stays on from ADDR through RECOVER, and across back-to-back writes
            oe_b_q <= !((state_d != IDLE) && we_d);

            vid_ack_q    <= grant_vid;
            cpu_ack_q    <= grant_cpu;
            vid_rvalid_q <= read_done && (port_q == PORT_VID);
            cpu_rvalid_q <= read_done && (port_q == PORT_CPU);
            if (read_done && port_q == PORT_VID) vid_rdata_q <= bus.i_ram_rdata;
            if (read_done && port_q == PORT_CPU) cpu_rdata_q <= bus.i_ram_rdata;
        end
    end

    assign bus.o_ram_ce_b      = ce_b_q;
    assign bus.o_ram_re_b      = re_b_q;
    assign bus.o_ram_we_b      = we_b_q;
    assign bus.o_ram_data_oe_b = oe_b_q;
    assign bus.o_ram_addr      = addr_q;
    assign bus.o_ram_wdata     = wdata_q;
    assign bus.o_vid_ack       = vid_ack_q;
    assign bus.o_cpu_ack       = cpu_ack_q;
    assign bus.o_vid_rvalid    = vid_rvalid_q;
    assign bus.o_cpu_rvalid    = cpu_rvalid_q;
    assign bus.o_vid_rdata     = vid_rdata_q;
    assign bus.o_cpu_rdata     = cpu_rdata_q;
    assign bus.o_busy          = (state_q != IDLE);
endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench for vram_access_arbiter: two instances (StrobeCycles 2 and 1) sharing one
// zero-delay SRAM model preloaded with mem[i] = i[7:0].
module tb_vram_access_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    vram_access_arbiter_if #(.AddrWidth(16)) bus  ();
    vram_access_arbiter_if #(.AddrWidth(16)) bus2 ();

    vram_access_arbiter #(.AddrWidth(16), .StrobeCycles(2)) dut (
        .i_clk(clk), .i_rst_b(rst_n), .bus(bus.master));
    vram_access_arbiter #(.AddrWidth(16), .StrobeCycles(1)) dut2 (
        .i_clk(clk), .i_rst_b(rst_n), .bus(bus2.master));

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    initial for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
    always @(posedge bus.o_ram_we_b)
        if (bus.o_ram_ce_b === 1'b0) mem[bus.o_ram_addr] = bus.o_ram_wdata;
    assign bus.i_ram_rdata  = (!bus.o_ram_ce_b && !bus.o_ram_re_b) ? mem[bus.o_ram_addr] : 8'h00;
    assign bus2.i_ram_rdata = (!bus2.o_ram_ce_b && !bus2.o_ram_re_b) ? mem[bus2.o_ram_addr] : 8'h00;

    // per-cycle samples, bit k = cycle k after the first edge of a capture
    logic [31:0] s_ce_b, s_re_b, s_we_b, s_oe_b, s_ack_v, s_ack_c, s_rv_v, s_rv_c, s_busy;

    task automatic capture(input int ncyc, input bit hold, input bit sel);
        s_ce_b = '1; s_re_b = '1; s_we_b = '1; s_oe_b = '1;
        s_ack_v = '0; s_ack_c = '0; s_rv_v = '0; s_rv_c = '0; s_busy = '0;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            if (!sel) begin
                s_ce_b[k] = bus.o_ram_ce_b;   s_re_b[k] = bus.o_ram_re_b;
                s_we_b[k] = bus.o_ram_we_b;   s_oe_b[k] = bus.o_ram_data_oe_b;
                s_ack_v[k] = bus.o_vid_ack;   s_ack_c[k] = bus.o_cpu_ack;
                s_rv_v[k] = bus.o_vid_rvalid; s_rv_c[k] = bus.o_cpu_rvalid;
                s_busy[k] = bus.o_busy;
                if (!hold && bus.o_vid_ack) bus.i_vid_req = 1'b0;
                if (!hold && bus.o_cpu_ack) bus.i_cpu_req = 1'b0;
            end else begin
                s_ce_b[k] = bus2.o_ram_ce_b;   s_re_b[k] = bus2.o_ram_re_b;
                s_we_b[k] = bus2.o_ram_we_b;   s_oe_b[k] = bus2.o_ram_data_oe_b;
                s_ack_v[k] = bus2.o_vid_ack;   s_ack_c[k] = bus2.o_cpu_ack;
                s_rv_v[k] = bus2.o_vid_rvalid; s_rv_c[k] = bus2.o_cpu_rvalid;
                s_busy[k] = bus2.o_busy;
                if (!hold && bus2.o_vid_ack) bus2.i_vid_req = 1'b0;
            end
            n_checks++;
            if ((!s_re_b[k] && !s_we_b[k]) || (!s_re_b[k] && !s_oe_b[k])) begin
                n_errors++;
                $display("FAIL strobe_overlap cycle %0d: re_b=%b we_b=%b oe_b=%b, required no overlap",
                         k, s_re_b[k], s_we_b[k], s_oe_b[k]);
            end
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk); #1;
            if (!bus.o_busy) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL idle_timeout: o_busy=%b after 20 cycles, required 0", bus.o_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_vid_req = 1'b1; bus.i_vid_addr = 16'h0020;
        bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 16'h0030; bus.i_cpu_wdata = 8'h00;
        bus2.i_vid_req = 1'b0; bus2.i_vid_addr = 16'h0000;
        bus2.i_cpu_req = 1'b0; bus2.i_cpu_we = 1'b0; bus2.i_cpu_addr = 16'h0000; bus2.i_cpu_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.o_ram_ce_b, bus.o_ram_re_b, bus.o_ram_we_b, bus.o_ram_data_oe_b} !== 4'b1111) begin
            n_errors++;
            $display("FAIL reset_strobes: ce/re/we/oe=%b, required 1111",
                     {bus.o_ram_ce_b, bus.o_ram_re_b, bus.o_ram_we_b, bus.o_ram_data_oe_b});
        end
        n_checks++;
        if ({bus.o_vid_ack, bus.o_cpu_ack, bus.o_vid_rvalid, bus.o_cpu_rvalid, bus.o_busy} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags: ack_v/ack_c/rv_v/rv_c/busy=%b, required 00000",
                     {bus.o_vid_ack, bus.o_cpu_ack, bus.o_vid_rvalid, bus.o_cpu_rvalid, bus.o_busy});
        end
        n_checks++;
        if (bus.o_ram_addr !== 16'h0 || bus.o_vid_rdata !== 8'h0 || bus.o_cpu_rdata !== 8'h0) begin
            n_errors++;
            $display("FAIL reset_regs: addr=%h vid_rdata=%h cpu_rdata=%h, required 0",
                     bus.o_ram_addr, bus.o_vid_rdata, bus.o_cpu_rdata);
        end
    endtask

    task automatic test_alternation();
        @(negedge clk) rst_n = 1'b1;
        capture(16, 1'b1, 1'b0);
        bus.i_vid_req = 1'b0; bus.i_cpu_req = 1'b0;
        n_checks++;
        if (s_ack_v[16:1] !== 16'h0101 || s_ack_c[16:1] !== 16'h1010) begin
            n_errors++;
            $display("FAIL alt_acks: vid=%h cpu=%h, required vid=0101 cpu=1010", s_ack_v[16:1], s_ack_c[16:1]);
        end
        n_checks++;
        if (s_busy[16:1] !== 16'hFFFF || s_ce_b[16:1] !== 16'h0000) begin
            n_errors++;
            $display("FAIL alt_no_idle: busy=%h ce_b=%h, required FFFF 0000", s_busy[16:1], s_ce_b[16:1]);
        end
        n_checks++;
        if (s_re_b[16:1] !== 16'h9999) begin
            n_errors++;
            $display("FAIL alt_re_b: got %h, required 9999", s_re_b[16:1]);
        end
        n_checks++;
        if (s_rv_v[16:1] !== 16'h0808 || s_rv_c[16:1] !== 16'h8080) begin
            n_errors++;
            $display("FAIL alt_rvalid: vid=%h cpu=%h, required 0808 8080", s_rv_v[16:1], s_rv_c[16:1]);
        end
        wait_idle();
        n_checks++;
        if (bus.o_vid_rdata !== 8'h20 || bus.o_cpu_rdata !== 8'h30) begin
            n_errors++;
            $display("FAIL alt_rdata: vid=%h cpu=%h, required 20 30", bus.o_vid_rdata, bus.o_cpu_rdata);
        end
    endtask

    task automatic test_video_read();
        bus.i_vid_addr = 16'h1234; bus.i_vid_req = 1'b1;
        capture(5, 1'b0, 1'b0);
        n_checks++;
        if (s_ack_v[5:1] !== 5'b00001 || s_ack_c[5:1] !== 5'b00000) begin
            n_errors++;
            $display("FAIL vid_ack: vid=%b cpu=%b, required 00001 00000", s_ack_v[5:1], s_ack_c[5:1]);
        end
        n_checks++;
        if (s_re_b[5:1] !== 5'b11001 || s_we_b[5:1] !== 5'b11111 || s_oe_b[5:1] !== 5'b11111) begin
            n_errors++;
            $display("FAIL vid_strobes: re_b=%b we_b=%b oe_b=%b, required 11001 11111 11111",
                     s_re_b[5:1], s_we_b[5:1], s_oe_b[5:1]);
        end
        n_checks++;
        if (s_rv_v[5:1] !== 5'b01000 || s_busy[5:1] !== 5'b01111 || s_ce_b[5:1] !== 5'b10000) begin
            n_errors++;
            $display("FAIL vid_timing: rvalid=%b busy=%b ce_b=%b, required 01000 01111 10000",
                     s_rv_v[5:1], s_busy[5:1], s_ce_b[5:1]);
        end
        n_checks++;
        if (bus.o_vid_rdata !== 8'h34) begin
            n_errors++;
            $display("FAIL vid_rdata: got %h, required 34", bus.o_vid_rdata);
        end
    endtask

    task automatic test_cpu_write_read();
        bus.i_cpu_addr = 16'h0100; bus.i_cpu_wdata = 8'hA5; bus.i_cpu_we = 1'b1; bus.i_cpu_req = 1'b1;
        capture(5, 1'b0, 1'b0);
        n_checks++;
        if (s_we_b[5:1] !== 5'b11001 || s_re_b[5:1] !== 5'b11111) begin
            n_errors++;
            $display("FAIL wr_strobes: we_b=%b re_b=%b, required 11001 11111", s_we_b[5:1], s_re_b[5:1]);
        end
        n_checks++;
        if (s_oe_b[5:1] !== 5'b10000 || s_ack_c[5:1] !== 5'b00001 || s_rv_c[5:1] !== 5'b00000) begin
            n_errors++;
            $display("FAIL wr_oe_ack: oe_b=%b ack=%b rvalid=%b, required 10000 00001 00000",
                     s_oe_b[5:1], s_ack_c[5:1], s_rv_c[5:1]);
        end
        bus.i_cpu_wdata = 8'h00; bus.i_cpu_we = 1'b0; bus.i_cpu_req = 1'b1;
        capture(5, 1'b0, 1'b0);
        n_checks++;
        if (s_re_b[5:1] !== 5'b11001 || s_rv_c[5:1] !== 5'b01000 || s_oe_b[5:1] !== 5'b11111) begin
            n_errors++;
            $display("FAIL rd_timing: re_b=%b rvalid=%b oe_b=%b, required 11001 01000 11111",
                     s_re_b[5:1], s_rv_c[5:1], s_oe_b[5:1]);
        end
        n_checks++;
        if (bus.o_cpu_rdata !== 8'hA5 || bus.o_vid_rdata !== 8'h34) begin
            n_errors++;
            $display("FAIL rd_data: cpu=%h vid=%h, required A5 34", bus.o_cpu_rdata, bus.o_vid_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        bus.i_cpu_addr = 16'h0200; bus.i_cpu_we = 1'b0; bus.i_cpu_req = 1'b1;
        @(posedge clk); #1;
        bus.i_cpu_req = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.o_ram_re_b !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_strobe: re_b=%b in first STROBE cycle, required 0", bus.o_ram_re_b);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_ram_ce_b, bus.o_ram_re_b, bus.o_busy} !== 3'b110) begin
            n_errors++;
            $display("FAIL mid_reset_async: ce/re/busy=%b, required 110",
                     {bus.o_ram_ce_b, bus.o_ram_re_b, bus.o_busy});
        end
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
                @(negedge clk) rst_n = 1'b1;
            end
            @(posedge clk); #1;
            n_checks++;
            if (bus.o_cpu_rvalid !== 1'b0 || bus.o_cpu_ack !== 1'b0 || bus.o_busy !== 1'b0) begin
                n_errors++;
                $display("FAIL mid_dropped: rvalid=%b ack=%b busy=%b, required 000",
                         bus.o_cpu_rvalid, bus.o_cpu_ack, bus.o_busy);
            end
        end
        bus.i_vid_addr = 16'h0010; bus.i_vid_req = 1'b1;
        capture(5, 1'b0, 1'b0);
        n_checks++;
        if (s_rv_v[5:1] !== 5'b01000 || bus.o_vid_rdata !== 8'h10 || bus.o_cpu_rdata !== 8'h00) begin
            n_errors++;
            $display("FAIL post_reset_read: rvalid=%b vid=%h cpu=%h, required 01000 10 00",
                     s_rv_v[5:1], bus.o_vid_rdata, bus.o_cpu_rdata);
        end
    endtask

    task automatic test_strobe1();
        bus2.i_vid_addr = 16'h00FF; bus2.i_vid_req = 1'b1;
        capture(4, 1'b0, 1'b1);
        n_checks++;
        if (s_ack_v[4:1] !== 4'b0001 || s_re_b[4:1] !== 4'b1101) begin
            n_errors++;
            $display("FAIL s1_ack_re: ack=%b re_b=%b, required 0001 1101", s_ack_v[4:1], s_re_b[4:1]);
        end
        n_checks++;
        if (s_rv_v[4:1] !== 4'b0100 || s_busy[4:1] !== 4'b0111 || bus2.o_vid_rdata !== 8'hFF) begin
            n_errors++;
            $display("FAIL s1_timing: rvalid=%b busy=%b rdata=%h, required 0100 0111 FF",
                     s_rv_v[4:1], s_busy[4:1], bus2.o_vid_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_alternation();
        test_video_read();
        wait_idle();
        test_cpu_write_read();
        wait_idle();
        test_reset_mid_access();
        wait_idle();
        test_strobe1();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
